// File: rtl/decoder_nx2n_scan_pkg.sv
// Shared definitions for the decoder/demux family: mode encodings and a
// one-hot helper sized for the widest supported select (5 bits, 32 lines).
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int MAX_N     = 5;
  localparam int MAX_OUT_W = 1 << MAX_N;

  // Callers truncate the result to their own 2**N output width.
  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_N-1:0] idx);
    logic [MAX_OUT_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_nx2n_scan_dwell_tick.sv
// Dwell timer: emits a one-cycle tick on every DWELL-th cycle while run is
// high. clr zeroes the count and suppresses the tick; run low holds the count.
module dwell_tick #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The tick is taken from the registered count so the consumer can act on
  // the same edge that rolls the counter back to zero.
  assign tick = run && !clr && (cnt_q == CNT_LAST);

  // Next count: clear wins, then advance/roll over, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_nx2n_scan.sv
// Registered N-to-2^N decoder with enable and an auto-scan mode that walks a
// single active line through all outputs, DWELL cycles per line.
module decoder_nx2n_scan
  import decoder_pkg::*;
#(
  parameter int N          = 2,
  parameter int DWELL      = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [N-1:0]        a,
  output logic [(1<<N)-1:0]   q,
  output logic [N-1:0]        idx,
  output logic                wrap
);

  localparam int OUT_W = 1 << N;
  localparam logic [OUT_W-1:0] Q_POL    = ACTIVE_LOW ? '1 : '0;
  localparam logic [N-1:0]     IDX_LAST = '1;

  if (N < 1 || N > MAX_N) begin : g_bad_n
    $error("decoder_nx2n_scan: N must be in 1..5");
  end
  if (DWELL < 1) begin : g_bad_dwell
    $error("decoder_nx2n_scan: DWELL must be >= 1");
  end

  logic             scan_en;
  logic             direct_en;
  logic             tick;
  logic [N-1:0]     idx_q, idx_d;
  logic [OUT_W-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;

  assign scan_en   = en && (mode == MODE_SCAN);
  assign direct_en = en && (mode == MODE_DIRECT);

  // Direct mode clears the dwell count, so a later switch to scan always
  // starts with a full dwell on the last decoded index.
  dwell_tick #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk (clk),
    .rst (rst),
    .run (scan_en),
    .clr (direct_en),
    .tick(tick)
  );

  // Mode mux: direct load of a, scan advance on tick, hold while disabled.
  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (direct_en) begin
      idx_d = a;
    end else if (scan_en && tick) begin
      idx_d  = idx_q + N'(1);
      wrap_d = (idx_q == IDX_LAST);
    end
    q_d = '0;
    if (en) begin
      q_d = OUT_W'(onehot(MAX_N'(idx_d)));
    end
    q_d = q_d ^ Q_POL;
  end

  // Output registers; reset forces all lines inactive and restarts at idx 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      q_q    <= Q_POL;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_nx2n_scan.sv
// Bench for decoder_nx2n_scan: two builds (N=2/DWELL=4 active-high and
// N=3/DWELL=1 active-low) share one stimulus stream and are checked against
// a time-based reference: in scan mode the index is base + elapsed/DWELL.
module tb_decoder_nx2n_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en;
  logic       mode;
  logic [2:0] a;

  logic [3:0] qa;
  logic [1:0] ia;
  logic       wa;
  logic [7:0] qb;
  logic [2:0] ib;
  logic       wb;

  decoder_nx2n_scan #(.N(2), .DWELL(4), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a[1:0]),
    .q(qa), .idx(ia), .wrap(wa)
  );

  decoder_nx2n_scan #(.N(3), .DWELL(1), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a),
    .q(qb), .idx(ib), .wrap(wb)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference state per build: scan origin, cycles spent scanning since then,
  // registered enable and last wrap.
  int m_base[2];
  int m_el[2];
  bit m_en[2];
  bit m_wr[2];
  int m_lines[2] = '{4, 8};
  int m_dwell[2] = '{4, 1};

  logic [3:0] exp_qa;
  logic [1:0] exp_ia;
  logic       exp_wa;
  logic [7:0] exp_qb;
  logic [2:0] exp_ib;
  logic       exp_wb;

  task automatic model_edge();
    int cur [2];
    int ohv [2];
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_base[k] = 0; m_el[k] = 0; m_en[k] = 1'b0; m_wr[k] = 1'b0;
      end else if (!en) begin
        m_en[k] = 1'b0; m_wr[k] = 1'b0;
      end else if (!mode) begin
        m_base[k] = int'(a) % m_lines[k]; m_el[k] = 0;
        m_en[k] = 1'b1; m_wr[k] = 1'b0;
      end else begin
        int old_i;
        old_i = (m_base[k] + m_el[k] / m_dwell[k]) % m_lines[k];
        m_el[k]++;
        m_wr[k] = ((m_el[k] % m_dwell[k]) == 0) && (old_i == m_lines[k] - 1);
        m_en[k] = 1'b1;
      end
      cur[k] = (m_base[k] + m_el[k] / m_dwell[k]) % m_lines[k];
      ohv[k] = m_en[k] ? (1 << cur[k]) : 0;
    end
    exp_qa = 4'(ohv[0]);
    exp_ia = 2'(cur[0]);
    exp_wa = m_wr[0];
    exp_qb = ~8'(ohv[1]);
    exp_ib = 3'(cur[1]);
    exp_wb = m_wr[1];
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 1'b1; a = 3'($urandom);
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if ({qa, ia, wa} !== {exp_qa, exp_ia, exp_wa}) begin
        miscompares++;
        $display("FAIL reset_a: got q=%b idx=%0d wrap=%b, want q=%b idx=%0d wrap=%b", qa, ia, wa, exp_qa, exp_ia, exp_wa);
      end
      vectors++;
      if ({qa, qb, wa, wb} !== {4'b0000, 8'hFF, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_inactive: got qa=%b qb=%b wa=%b wb=%b, want 0000 11111111 0 0", qa, qb, wa, wb);
      end
    end
    rst = 1'b0; en = 1'b0;
    step();
    vectors++;
    if ({qa, ia, wa, qb, ib, wb} !== {exp_qa, exp_ia, exp_wa, exp_qb, exp_ib, exp_wb}) begin
      miscompares++;
      $display("FAIL reset_release: got qa=%b ia=%0d qb=%b ib=%0d, want qa=%b ia=%0d qb=%b ib=%0d", qa, ia, qb, ib, exp_qa, exp_ia, exp_qb, exp_ib);
    end
  endtask

  task automatic test_direct();
    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 3'(i);
      step();
      vectors++;
      if (qa !== 4'(1 << i)) begin
        miscompares++;
        $display("FAIL direct_a%0d: got q=%b, want q=%b", i, qa, 4'(1 << i));
      end
    end
    en = 1'b0;
    step();
    vectors++;
    if ({qa, qb, ia} !== {4'b0000, 8'hFF, 2'd3}) begin
      miscompares++;
      $display("FAIL direct_disable: got qa=%b qb=%b ia=%0d, want 0000 11111111 3", qa, qb, ia);
    end
    en = 1'b1; a = 3'd5;
    step();
    vectors++;
    if (qb !== 8'b11011111) begin
      miscompares++;
      $display("FAIL direct_b_a5: got q=%b, want 11011111", qb);
    end
    for (int i = 0; i < 20; i++) begin
      a = 3'($urandom);
      step();
      vectors++;
      if ({qa, ia, wa, qb, ib, wb} !== {exp_qa, exp_ia, exp_wa, exp_qb, exp_ib, exp_wb}) begin
        miscompares++;
        $display("FAIL direct_rand: got qa=%b qb=%b, want qa=%b qb=%b", qa, qb, exp_qa, exp_qb);
      end
    end
  endtask

  task automatic test_scan();
    int wraps_a;
    int wraps_b;
    wraps_a = 0; wraps_b = 0;
    rst = 1'b1; en = 1'b0;
    step();
    rst = 1'b0; en = 1'b1; mode = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      step();
      wraps_a += int'(wa);
      wraps_b += int'(wb);
      vectors++;
      if ({qa, ia, wa, qb, ib, wb} !== {exp_qa, exp_ia, exp_wa, exp_qb, exp_ib, exp_wb}) begin
        miscompares++;
        $display("FAIL scan_c%0d: got qa=%b wa=%b qb=%b wb=%b, want qa=%b wa=%b qb=%b wb=%b", c, qa, wa, qb, wb, exp_qa, exp_wa, exp_qb, exp_wb);
      end
      if (c == 16) begin
        vectors++;
        if ({qa, wa} !== {4'b0001, 1'b1}) begin
          miscompares++;
          $display("FAIL scan_wrap16: got q=%b wrap=%b, want 0001 1", qa, wa);
        end
      end
    end
    vectors++;
    if (wraps_a !== 2 || wraps_b !== 4) begin
      miscompares++;
      $display("FAIL scan_wrap_count: got a=%0d b=%0d, want a=2 b=4", wraps_a, wraps_b);
    end
  endtask

  task automatic test_pause();
    rst = 1'b1; en = 1'b0; mode = 1'b1;
    step();
    rst = 1'b0; en = 1'b1;
    repeat (9) step();
    vectors++;
    if ({qa, ia} !== {4'b0100, 2'd2}) begin
      miscompares++;
      $display("FAIL pause_pre: got q=%b idx=%0d, want 0100 2", qa, ia);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({qa, ia, qb, ib} !== {4'b0000, 2'd2, 8'hFF, exp_ib}) begin
        miscompares++;
        $display("FAIL pause_hold: got qa=%b ia=%0d qb=%b ib=%0d, want 0000 2 11111111 %0d", qa, ia, qb, ib, exp_ib);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({qa, ia, wa, qb, ib, wb} !== {exp_qa, exp_ia, exp_wa, exp_qb, exp_ib, exp_wb}) begin
        miscompares++;
        $display("FAIL pause_resume%0d: got qa=%b ia=%0d, want qa=%b ia=%0d", i, qa, ia, exp_qa, exp_ia);
      end
      vectors++;
      if (qa !== ((i < 2) ? 4'b0100 : 4'b1000)) begin
        miscompares++;
        $display("FAIL pause_resume_q%0d: got q=%b, want %b", i, qa, (i < 2) ? 4'b0100 : 4'b1000);
      end
    end
    mode = 1'b0; a = 3'd0;
    step();
    vectors++;
    if ({qa, qb} !== {4'b0001, 8'hFE}) begin
      miscompares++;
      $display("FAIL pause_to_direct: got qa=%b qb=%b, want 0001 11111110", qa, qb);
    end
  endtask

  task automatic test_priority();
    rst = 1'b1; en = 1'b0; mode = 1'b1;
    step();
    rst = 1'b0; en = 1'b1;
    repeat (3) step();
    mode = 1'b0; a = 3'd2;
    step();
    vectors++;
    if ({qa, ia, wa} !== {4'b0100, 2'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL mode_priority: got q=%b idx=%0d wrap=%b, want 0100 2 0", qa, ia, wa);
    end
    mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if ({qa, ia, wa, qb, ib, wb} !== {exp_qa, exp_ia, exp_wa, exp_qb, exp_ib, exp_wb}) begin
        miscompares++;
        $display("FAIL scan_from_a%0d: got qa=%b ia=%0d, want qa=%b ia=%0d", i, qa, ia, exp_qa, exp_ia);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      en  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      a = 3'($urandom);
      step();
      vectors++;
      if ({qa, ia, wa, qb, ib, wb} !== {exp_qa, exp_ia, exp_wa, exp_qb, exp_ib, exp_wb}) begin
        miscompares++;
        $display("FAIL random_%0d: got qa=%b ia=%0d wa=%b qb=%b ib=%0d wb=%b, want qa=%b ia=%0d wa=%b qb=%b ib=%0d wb=%b",
                 i, qa, ia, wa, qb, ib, wb, exp_qa, exp_ia, exp_wa, exp_qb, exp_ib, exp_wb);
      end
      vectors++;
      if ($countones(qa) !== (m_en[0] ? 1 : 0) || $countones(~qb) !== (m_en[1] ? 1 : 0)) begin
        miscompares++;
        $display("FAIL random_onehot_%0d: got qa=%b qb=%b, want %0d active line(s)", i, qa, qb, m_en[0] ? 1 : 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; a = 3'd0;
    test_reset();
    test_direct();
    test_scan();
    test_pause();
    test_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
